// File: rtl/fp_result_scoreboard.sv
// Result scoreboard: buffers a DUT and a reference result stream in two FIFOs and compares them in pairs.
// Optional macro SB_ULP_TOL_EN also passes non-overflow pairs of equal sign whose magnitudes differ by <= ULP_TOL.
module fp_result_scoreboard #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int ULP_TOL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_valid,
  input  logic [WIDTH-1:0] dut_result,
  input  logic             dut_ovf,
  output logic             dut_ready,
  input  logic             ref_valid,
  input  logic [WIDTH-1:0] ref_result,
  input  logic             ref_ovf,
  output logic             ref_ready,
  input  logic             clear,
  output logic             cmp_valid,
  output logic             cmp_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [WIDTH-1:0] first_fail_dut,
  output logic [WIDTH-1:0] first_fail_ref
);

  localparam int AW = $clog2(DEPTH);

  // Each entry holds {ovf, result}.
  logic [WIDTH:0] dut_mem [DEPTH];
  logic [WIDTH:0] ref_mem [DEPTH];
  logic [AW:0]    dut_wp, dut_rp, ref_wp, ref_rp;

  logic dut_full, dut_empty, ref_full, ref_empty;
  logic dut_push, ref_push, pop;
  logic [WIDTH:0] dut_head, ref_head;
  logic pair_pass;

  // The extra pointer bit differs only when the writer has lapped the reader.
  assign dut_full  = (dut_wp[AW] != dut_rp[AW]) && (dut_wp[AW-1:0] == dut_rp[AW-1:0]);
  assign ref_full  = (ref_wp[AW] != ref_rp[AW]) && (ref_wp[AW-1:0] == ref_rp[AW-1:0]);
  assign dut_empty = (dut_wp == dut_rp);
  assign ref_empty = (ref_wp == ref_rp);

  assign dut_ready = !dut_full;
  assign ref_ready = !ref_full;
  assign dut_push  = dut_valid && !dut_full;
  assign ref_push  = ref_valid && !ref_full;
  assign pop       = !dut_empty && !ref_empty;

  assign dut_head = dut_mem[dut_rp[AW-1:0]];
  assign ref_head = ref_mem[ref_rp[AW-1:0]];

`ifdef SB_ULP_TOL_EN
  localparam logic [WIDTH-2:0] TOL = (WIDTH-1)'(ULP_TOL);
  logic [WIDTH-2:0] dut_mag, ref_mag, mag_diff;

  assign dut_mag  = dut_head[WIDTH-2:0];
  assign ref_mag  = ref_head[WIDTH-2:0];
  assign mag_diff = (dut_mag >= ref_mag) ? (dut_mag - ref_mag) : (ref_mag - dut_mag);

  always_comb begin
    pair_pass = (dut_head[WIDTH-1:0] == ref_head[WIDTH-1:0]) || (dut_head[WIDTH] && ref_head[WIDTH]);
    if (!dut_head[WIDTH] && !ref_head[WIDTH] &&
        (dut_head[WIDTH-1] == ref_head[WIDTH-1]) && (mag_diff <= TOL))
      pair_pass = 1'b1;
  end
`else
  localparam int unused_ulp_tol = ULP_TOL;

  always_comb begin
    pair_pass = (dut_head[WIDTH-1:0] == ref_head[WIDTH-1:0]) || (dut_head[WIDTH] && ref_head[WIDTH]);
  end
`endif

  // NOTE: FIFO storage is left unreset; the pointers alone define what is valid, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (dut_push) dut_mem[dut_wp[AW-1:0]] <= {dut_ovf, dut_result};
    if (ref_push) ref_mem[ref_wp[AW-1:0]] <= {ref_ovf, ref_result};
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dut_wp         <= '0;
      dut_rp         <= '0;
      ref_wp         <= '0;
      ref_rp         <= '0;
      cmp_valid      <= 1'b0;
      cmp_pass       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      fail_seen      <= 1'b0;
      first_fail_dut <= '0;
      first_fail_ref <= '0;
    end else begin
      if (dut_push) dut_wp <= dut_wp + (AW+1)'(1);
      if (ref_push) ref_wp <= ref_wp + (AW+1)'(1);
      if (pop) begin
        dut_rp <= dut_rp + (AW+1)'(1);
        ref_rp <= ref_rp + (AW+1)'(1);
      end

      cmp_valid <= pop;
      cmp_pass  <= pop && pair_pass;

      // Clear wins over a same-cycle compare; the verdict strobe still goes out.
      if (clear) begin
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        fail_seen      <= 1'b0;
        first_fail_dut <= '0;
        first_fail_ref <= '0;
      end else if (pop) begin
        if (pair_pass) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          if (!fail_seen) begin
            fail_seen      <= 1'b1;
            first_fail_dut <= dut_head[WIDTH-1:0];
            first_fail_ref <= ref_head[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_result_scoreboard.sv
// Directed bench for fp_result_scoreboard: stimulus queues expected verdicts, a negedge monitor checks them.
// Build with +define+SB_ULP_TOL_EN to exercise the tolerance expectations.
module tb_fp_result_scoreboard;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

`ifdef SB_ULP_TOL_EN
  localparam bit ULP = 1'b1;
`else
  localparam bit ULP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             dut_valid, ref_valid, dut_ovf, ref_ovf, clear;
  logic [WIDTH-1:0] dut_result, ref_result;
  logic             dut_ready, ref_ready, cmp_valid, cmp_pass, fail_seen;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [WIDTH-1:0] first_fail_dut, first_fail_ref;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  fp_result_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .ULP_TOL(1)) dut (
    .clk(clk), .reset(reset),
    .dut_valid(dut_valid), .dut_result(dut_result), .dut_ovf(dut_ovf), .dut_ready(dut_ready),
    .ref_valid(ref_valid), .ref_result(ref_result), .ref_ovf(ref_ovf), .ref_ready(ref_ready),
    .clear(clear), .cmp_valid(cmp_valid), .cmp_pass(cmp_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
    .first_fail_dut(first_fail_dut), .first_fail_ref(first_fail_ref)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every verdict strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cmp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmp", 32'(cmp_valid), 32'd0);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("cmp_pass", 32'(cmp_pass), 32'(e));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pair(input logic [31:0] d, input logic dovf, input logic [31:0] r,
                           input logic rovf, input bit exp_pass);
    exp_q.push_back(exp_pass);
    dut_valid = 1'b1; dut_result = d; dut_ovf = dovf;
    ref_valid = 1'b1; ref_result = r; ref_ovf = rovf;
    step(1);
    dut_valid = 1'b0;
    ref_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0;
    dut_valid = 1'b0; ref_valid = 1'b0; dut_ovf = 1'b0; ref_ovf = 1'b0;
    dut_result = '0; ref_result = '0;
    step(3);
    reset = 1'b1;
    check("rst_dut_ready", 32'(dut_ready), 32'd1);
    check("rst_ref_ready", 32'(ref_ready), 32'd1);
    check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    check("rst_fail_seen", 32'(fail_seen), 32'd0);

    // Exact match and latency.
    push_pair(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b1);
    check("lat_no_early_cmp", 32'(cmp_valid), 32'd0);
    step(1);
    check("lat_cmp_valid", 32'(cmp_valid), 32'd1);
    check("lat_cmp_pass", 32'(cmp_pass), 32'd1);
    check("lat_pass_cnt", 32'(pass_cnt), 32'd1);
    step(1);
    check("lat_strobe_one_cycle", 32'(cmp_valid), 32'd0);

    // Overflow equivalence, then a 1-ulp miss.
    do_clear();
    push_pair(32'h7F800000, 1'b1, 32'h12345678, 1'b1, 1'b1);
    push_pair(32'h40000000, 1'b0, 32'h40000001, 1'b0, ULP);
    step(1);
    check("ovf_pass_cnt", 32'(pass_cnt), ULP ? 32'd2 : 32'd1);
    check("ovf_fail_cnt", 32'(fail_cnt), ULP ? 32'd0 : 32'd1);
    check("ovf_fail_seen", 32'(fail_seen), ULP ? 32'd0 : 32'd1);
    check("ovf_first_dut", first_fail_dut, ULP ? 32'h0 : 32'h40000000);
    check("ovf_first_ref", first_fail_ref, ULP ? 32'h0 : 32'h40000001);

    // Tolerance boundaries plus a single-sided overflow.
    do_clear();
    push_pair(32'h40000000, 1'b0, 32'h40000001, 1'b0, ULP);
    push_pair(32'h40000001, 1'b0, 32'h40000000, 1'b0, ULP);
    push_pair(32'h40000000, 1'b0, 32'h40000002, 1'b0, 1'b0);
    push_pair(32'hC0000000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    push_pair(32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
    step(1);
    check("ulp_pass_cnt", 32'(pass_cnt), ULP ? 32'd2 : 32'd0);
    check("ulp_fail_cnt", 32'(fail_cnt), ULP ? 32'd3 : 32'd5);
    check("ulp_first_dut", first_fail_dut, 32'h40000000);
    check("ulp_first_ref", first_fail_ref, ULP ? 32'h40000002 : 32'h40000001);

    // Later fails must not overwrite the capture; clear colliding with a failing pop wins.
    push_pair(32'h11111111, 1'b0, 32'h22222222, 1'b0, 1'b0);
    check("keep_first_pre", 32'(fail_seen), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_cmp_valid", 32'(cmp_valid), 32'd1);
    check("clr_fail_cnt", 32'(fail_cnt), 32'd0);
    check("clr_pass_cnt", 32'(pass_cnt), 32'd0);
    check("clr_fail_seen", 32'(fail_seen), 32'd0);
    check("clr_first_dut", first_fail_dut, 32'h0);
    check("clr_first_ref", first_fail_ref, 32'h0);

    // Saturation of the 4-bit pass counter.
    for (int i = 0; i < 17; i++) push_pair(32'(i), 1'b0, 32'(i), 1'b0, 1'b1);
    step(1);
    check("sat_pass_cnt", 32'(pass_cnt), 32'hF);
    check("sat_fail_cnt", 32'(fail_cnt), 32'd0);

    // Full DUT FIFO: four words fill it, a fifth is refused.
    do_clear();
    for (int i = 0; i < 4; i++) begin
      dut_valid = 1'b1; dut_result = 32'(i + 1); dut_ovf = 1'b0;
      step(1);
      check("full_dut_ready", 32'(dut_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    dut_result = 32'd99;
    step(2);
    check("full_holds_ready_low", 32'(dut_ready), 32'd0);
    dut_valid = 1'b0;
    check("full_no_cmp", 32'(cmp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3);
      ref_valid = 1'b1; ref_result = (i < 3) ? 32'(i + 1) : 32'd5; ref_ovf = 1'b0;
      step(1);
      check("full_consec_cmp", 32'(cmp_valid), (i > 0) ? 32'd1 : 32'd0);
    end
    ref_valid = 1'b0;
    step(1);
    check("full_last_cmp", 32'(cmp_valid), 32'd1);
    step(1);
    check("full_cmp_done", 32'(cmp_valid), 32'd0);
    check("full_pass_cnt", 32'(pass_cnt), 32'd3);
    check("full_fail_cnt", 32'(fail_cnt), 32'd1);
    check("full_dut_ready_back", 32'(dut_ready), 32'd1);
    // A lone ref word must find the DUT FIFO empty (the refused word was not stored).
    ref_valid = 1'b1; ref_result = 32'd7;
    step(1);
    ref_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("full_fifth_dropped", 32'(cmp_valid), 32'd0);
    end

    // Reset with two ref words buffered.
    ref_valid = 1'b1; ref_result = 32'd8;
    step(1);
    ref_valid = 1'b0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("mrst_dut_ready", 32'(dut_ready), 32'd1);
    check("mrst_ref_ready", 32'(ref_ready), 32'd1);
    check("mrst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("mrst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("mrst_fail_cnt", 32'(fail_cnt), 32'd0);
    dut_valid = 1'b1; dut_result = 32'd8;
    step(2);
    dut_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("mrst_fifo_flushed", 32'(cmp_valid), 32'd0);
    end

    // Reset landing on the edge of a pending pop discards the verdict.
    dut_valid = 1'b1; ref_valid = 1'b1; dut_result = 32'd1; ref_result = 32'd1;
    step(1);
    dut_valid = 1'b0; ref_valid = 1'b0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("prst_cmp_valid", 32'(cmp_valid), 32'd0);
    step(1);
    check("prst_no_late_cmp", 32'(cmp_valid), 32'd0);

    step(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_result_scoreboard.md
FP_RESULT_SCOREBOARD -- requirements
Module: fp_result_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, result word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per input FIFO; power of two, >= 2.
REQ-003 SHALL have parameter CNT_W, default 16, width of the pass and fail counters.
REQ-004 SHALL have parameter ULP_TOL, default 1, tolerance in units of last place; used only when SB_ULP_TOL_EN is defined.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have ports dut_valid  input  1; dut_result  input  WIDTH; dut_ovf  input  1: DUT result stream.
REQ-008 SHALL have port dut_ready  output  1  DUT FIFO can accept a word.
REQ-009 SHALL have ports ref_valid  input  1; ref_result  input  WIDTH; ref_ovf  input  1: reference-model result stream.
REQ-010 SHALL have port ref_ready  output  1  reference FIFO can accept a word.
REQ-011 SHALL have port clear  input  1  synchronous clear of counters and the failure capture.
REQ-012 SHALL have ports cmp_valid  output  1 and cmp_pass  output  1: per-comparison strobe and verdict.
REQ-013 SHALL have ports pass_cnt and fail_cnt  output  CNT_W each: running totals.
REQ-014 SHALL have ports fail_seen  output  1; first_fail_dut and first_fail_ref  output  WIDTH each: first failing pair.

Function
REQ-015 SHALL buffer each stream in its own DEPTH-entry FIFO; a push occurs when valid && ready at a rising edge.
REQ-016 SHALL drive dut_ready = !dut_full and ref_ready = !ref_full, with no bypass; a full FIFO accepts no push, even when it is popped in the same cycle.
REQ-017 SHALL wrap read and write pointers modulo DEPTH, and SHALL distinguish full from empty with an extra pointer bit.
REQ-018 SHALL pop both FIFO heads in the same cycle whenever both FIFOs are non-empty; if either FIFO is empty, there is no pop and no compare.
REQ-019 SHALL register the verdict: for a pop at edge N, cmp_valid and cmp_pass are high for exactly the cycle after edge N; a word pushed at edge N pops no earlier than edge N+1.
REQ-020 SHALL set pass = (dut_result == ref_result) || (dut_ovf && ref_ovf).
REQ-021 SHALL increment pass_cnt or fail_cnt by one per compare, saturating at all-ones.
REQ-022 SHALL, on the first fail after reset or clear, capture both results into first_fail_dut/first_fail_ref and set fail_seen; later fails leave the capture unchanged.
REQ-023 SHALL give clear priority over a same-cycle compare: the counters and capture go to zero, the compare is not counted, cmp_valid still pulses, and the FIFO contents are untouched.
REQ-024 SHALL allow a push and a pop on the same FIFO in the same cycle when the FIFO is not full; occupancy is then unchanged.

Reset
REQ-025 SHALL, while reset == 0 at a rising edge, empty both FIFOs and zero all outputs except dut_ready and ref_ready, which read 1 from the cycle after reset.
REQ-026 SHALL, when reset is asserted mid-stream, discard all buffered words and any pending verdict; cmp_valid is 0 in the cycle following reset.

Configuration
REQ-027 SHALL, when SB_ULP_TOL_EN is defined, also pass a pair if:
- both ovf flags are 0,
- the sign bits (bit WIDTH-1) are equal,
- |dut_result[WIDTH-2:0] - ref_result[WIDTH-2:0]| <= ULP_TOL.
REQ-028 SHALL, when SB_ULP_TOL_EN is undefined, use REQ-020 exactly and ignore ULP_TOL.

Verification
REQ-029 SHALL cover exact match: push dut 3F800000/ovf0 and ref 3F800000/ovf0 in the same cycle -> cmp_valid and cmp_pass high two cycles later; pass_cnt = 1.
REQ-030 SHALL cover overflow equivalence: dut 7F800000/ovf1, ref 12345678/ovf1 -> pass; then dut 40000000/ovf0, ref 40000001/ovf0 -> fail without the macro; fail_seen = 1; first_fail_dut = 40000000; first_fail_ref = 40000001.
REQ-031 SHALL cover the full FIFO: push 4 dut words with no ref words -> dut_ready = 0 after the 4th push; a 5th dut_valid is not accepted; 4 ref words then yield 4 compares on consecutive cycles.
REQ-032 SHALL cover ULP tolerance (SB_ULP_TOL_EN, ULP_TOL = 1): 40000000 vs 40000001 -> pass; 40000000 vs 40000002 -> fail; C0000000 vs 40000000 -> fail.
REQ-033 SHALL cover clear collision and reset: assert clear in the cycle of a failing pop -> fail_cnt = 0 and fail_seen = 0; drive reset = 0 with 2 words buffered -> no cmp_valid afterwards and both readys = 1.
REQ-034 SHALL cover saturation: with CNT_W = 4, perform 17 passing compares -> pass_cnt holds at F.
